// File: rtl/adder_pipe_n.sv
// adder_pipe_n: pipelined WIDTH-bit two's-complement adder/subtractor with a valid/ready
// handshake and one register stage per SEG-bit carry segment. Define ADDER_SAT_EN to saturate on signed overflow.
module adder_pipe_n #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ent_acarreo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             sal_acarreo,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_param_check
    $error("adder_pipe_n: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
  end

  // Per-stage state: operands travel with their partial result so each stage sees
  // the full vectors, and the carry out of the segment just resolved.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_stall;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic             w_in_vld [STAGES];
  logic [WIDTH-1:0] w_in_a   [STAGES];
  logic [WIDTH-1:0] w_in_b   [STAGES];
  logic [WIDTH-1:0] w_in_s   [STAGES];
  logic             w_in_c   [STAGES];
  logic [WIDTH-1:0] w_new_s  [STAGES];
  logic             w_new_c  [STAGES];
  logic [WIDTH-1:0] w_out_s;
  logic             w_ovf;

  assign w_b_eff = sub ? ~b : b;
  assign w_cin   = sub ? 1'b1 : ent_acarreo;

  // The whole pipe freezes as one unit, bubbles included, so ordering never changes.
  assign w_stall  = r_vld[LAST] & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin : stage_inputs
    // NOTE: every combinational output is assigned on every path (stage 0 here, the
    // rest in the loop) so no latch can be inferred.
    w_in_vld[0] = in_valid;
    w_in_a[0]   = a;
    w_in_b[0]   = w_b_eff;
    w_in_s[0]   = '0;
    w_in_c[0]   = w_cin;
    for (int k = 1; k < STAGES; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_s[k]   = r_s[k-1];
      w_in_c[k]   = r_c[k-1];
    end
  end

  always_comb begin : stage_adders
    logic [SEG:0] w_seg;
    w_seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_seg = {1'b0, w_in_a[k][k*SEG +: SEG]}
            + {1'b0, w_in_b[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, w_in_c[k]};
      w_new_c[k]               = w_seg[SEG];
      w_new_s[k]               = w_in_s[k];
      w_new_s[k][k*SEG +: SEG] = w_seg[SEG-1:0];
    end
  end

  // Final stage: signed overflow from operand and result sign bits, optional clamp.
  always_comb begin : final_stage
    w_ovf   = (w_in_a[LAST][WIDTH-1] == w_in_b[LAST][WIDTH-1]) &&
              (w_new_s[LAST][WIDTH-1] != w_in_a[LAST][WIDTH-1]);
    w_out_s = w_new_s[LAST];
`ifdef ADDER_SAT_EN
    if (w_ovf) begin
      w_out_s = w_in_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset along with the valid bits because the
      // visible result outputs must read zero during and right after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_in_vld[k];
        if (w_in_vld[k]) begin
          r_a[k] <= w_in_a[k];
          r_b[k] <= w_in_b[k];
          r_s[k] <= (k == LAST) ? w_out_s : w_new_s[k];
          r_c[k] <= w_new_c[k];
        end
      end
      if (w_in_vld[LAST]) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid   = r_vld[LAST];
  assign sum         = r_s[LAST];
  assign sal_acarreo = r_c[LAST];
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_adder_pipe_n.sv
// tb_adder_pipe_n: directed checks of adder_pipe_n (16/4 and 8/8 instances);
// expected sums follow ADDER_SAT_EN when it is defined for the build.
module tb_adder_pipe_n;

`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, carry, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, carry8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int n_tests = 0;
  int n_fail  = 0;

  adder_pipe_n #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .ent_acarreo(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sal_acarreo(carry), .overflow(ovf)
  );

  adder_pipe_n #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .ent_acarreo(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .sal_acarreo(carry8), .overflow(ovf8)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s_wrap;
    logic [15:0] s_sat;
    logic        c;
    logic        v;
  } vec_t;

  function automatic vec_t get_vec(input int i);
    case (i)
      0:       return '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
      1:       return '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
      2:       return '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
      3:       return '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
      4:       return '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
      5:       return '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      6:       return '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
      7:       return '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 16'h5556, 1'b0, 1'b0};
      default: return '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
    endcase
  endfunction

  // Presents one operation on the 16-bit instance (called at posedge+1) and waits,
  // bounded, for out_valid; lat counts clock edges from the accepting edge.
  task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                        input logic tcin, output int lat);
    a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                       output int lat);
    a8 = ta; b8 = tb; sub8 = tsub; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; out_ready8 = 1'b1;
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ovf); end
    n_tests++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", out_valid8); end
    n_tests++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum8: got %h want 00", sum8); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8: got %b want 1", in_ready8); end
  endtask

  task automatic test_arith;
    vec_t        v;
    int          lat;
    logic [15:0] exp_s;
    for (int i = 0; i < 9; i++) begin
      v     = get_vec(i);
      exp_s = SAT ? v.s_sat : v.s_wrap;
      send16(v.a, v.b, v.sub, v.cin, lat);
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL arith[%0d]_latency: got %0d want 4", i, lat); end
      n_tests++; if (sum !== exp_s) begin n_fail++; $display("FAIL arith[%0d]_sum: got %h want %h", i, sum, exp_s); end
      n_tests++; if (carry !== v.c) begin n_fail++; $display("FAIL arith[%0d]_carry: got %b want %b", i, carry, v.c); end
      n_tests++; if (ovf !== v.v) begin n_fail++; $display("FAIL arith[%0d]_overflow: got %b want %b", i, ovf, v.v); end
    end
  endtask

  task automatic test_stages1;
    logic [7:0] ta [3]  = '{8'h80, 8'h7F, 8'h10};
    logic [7:0] tb [3]  = '{8'h80, 8'h01, 8'h25};
    logic       ts [3]  = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ew [3]  = '{8'h00, 8'h80, 8'hEB};
    logic [7:0] es [3]  = '{8'h80, 8'h7F, 8'hEB};
    logic       ec [3]  = '{1'b1, 1'b0, 1'b0};
    logic       ev [3]  = '{1'b1, 1'b1, 1'b0};
    logic [7:0] exp_s;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      exp_s = SAT ? es[i] : ew[i];
      send8(ta[i], tb[i], ts[i], lat);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL stages1[%0d]_latency: got %0d want 1", i, lat); end
      n_tests++; if (sum8 !== exp_s) begin n_fail++; $display("FAIL stages1[%0d]_sum: got %h want %h", i, sum8, exp_s); end
      n_tests++; if (carry8 !== ec[i]) begin n_fail++; $display("FAIL stages1[%0d]_carry: got %b want %b", i, carry8, ec[i]); end
      n_tests++; if (ovf8 !== ev[i]) begin n_fail++; $display("FAIL stages1[%0d]_overflow: got %b want %b", i, ovf8, ev[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_tab [6] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
    logic [15:0] exp_s [6] = '{16'h1012, 16'h2013, 16'h3014, 16'h4015, 16'h5016, 16'h6017};
    int n_in    = 0;
    int n_out   = 0;
    int n_stall = 0;
    int cyc     = 0;
    int extra   = 0;
    sub = 1'b0; cin = 1'b0; b = 16'h0011;
    while (n_out < 6 && cyc < 60) begin
      if (n_in < 6) begin
        in_valid = 1'b1;
        a        = a_tab[n_in];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1 && n_stall < 3) begin
        out_ready = 1'b0;
        n_stall++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_ready == 1'b0) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
        n_tests++; if (sum !== exp_s[n_out]) begin n_fail++; $display("FAIL b2b_stall_hold: got %h want %h", sum, exp_s[n_out]); end
      end else begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        if (n_stall == 3) begin
          n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got out_valid=%b want 1 (result %0d)", out_valid, n_out); end
        end
      end
      if (out_valid === 1'b1 && out_ready == 1'b1) begin
        n_tests++; if (sum !== exp_s[n_out]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", n_out, sum, exp_s[n_out]); end
        n_tests++; if ({carry, ovf} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags[%0d]: got %b want 00", n_out, {carry, ovf}); end
        n_out++;
      end
      if (in_valid && in_ready === 1'b1) n_in++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (n_out != 6) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 6", n_out); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) extra++;
      @(posedge clk); #1;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d extra valid cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen = 0;
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    a = 16'h0002; b = 16'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL rstmid_sum: got %h want 0000", sum); end
    n_tests++; if ({carry, ovf} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00", {carry, ovf}); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_ghost: got %0d valid cycles want 0", seen); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    send16(16'h0100, 16'h0200, 1'b0, 1'b0, lat);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 4", lat); end
    n_tests++; if (sum !== 16'h0300) begin n_fail++; $display("FAIL rstmid_sum_after: got %h want 0300", sum); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_stages1();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe_n.md
Name: adder_pipe_n

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- Successor to the fixed 8-bit ripple adder. Operand width is a parameter.
- The carry chain is cut into SEG-bit segments, with one register stage per segment.
- Operands are accepted on a valid/ready handshake with full backpressure. The block sits between operand registers and the datapath result bus.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, sub, ent_acarreo valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B+ent_acarreo, 1 = A−B (A + ~B + 1)
- ent_acarreo  input  1  carry in; ignored when sub=1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- sal_acarreo  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow of the operation

Behaviour:
- Reset:
  - Asynchronous on rst_n low: every stage valid bit, sum, sal_acarreo and overflow go to 0, and out_valid=0.
  - in_ready=1 immediately after release.
  - In-flight operations are discarded and never emerge.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Stall condition: stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, all stages hold, including empty bubbles. No data is lost and none is duplicated.
  - Result outputs are stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage k (0..STAGES−1) adds segment k of A and B' (B' = sub ? ~B : B) plus the carry registered from stage k−1.
  - Stage 0 carry-in = sub ? 1 : ent_acarreo.
  - Upper segments of A/B' and lower result segments are carried forward in skew registers.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accepting transfer to out_valid, with no stall.
  - Throughput is one operation per cycle.
  - Results leave in acceptance order.
- Arithmetic:
  - sum = (A + B' + cin) mod 2^WIDTH.
  - sal_acarreo = bit WIDTH of the full sum.
  - overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
- Bubbles: when in_valid=0 on a non-stalled cycle, a bubble enters. Stage valid bits track bubbles, and out_valid follows the last stage's valid bit.
- Simultaneous events:
  - When the pipeline is full and out_ready rises, input accept and output retire happen in the same cycle.
  - Input asserted during a stall is not accepted. The source must hold it (in_ready=0).
- STAGES=1 (SEG=WIDTH): single registered adder, latency 1.
- WIDTH not a multiple of SEG: elaboration-time error via generate check, not silent truncation.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - On overflow=1, sum saturates to the signed limit. A[MSB]=0 gives 0111…1; A[MSB]=1 gives 1000…0.
  - overflow is still reported; sal_acarreo is unchanged (raw carry).
  - The clamp is applied in the final stage; latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH, and no clamp logic is present.

Test Plan:
1. WIDTH=16, SEG=4, out_ready=1; a=0x00FF, b=0x0001, sub=0, ent_acarreo=0 → 4 cycles later out_valid=1, sum=0x0100, sal_acarreo=0, overflow=0.
2. Carry ripple across all segments: a=0xFFFF, b=0x0000, ent_acarreo=1 → sum=0x0000, sal_acarreo=1, overflow=0.
3. Subtract and signed overflow:
   - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, sal_acarreo=0.
   - a=0x7FFF, b=0x0001, sub=0 → overflow=1, sum=0x8000 (0x7FFF with ADDER_SAT_EN).
4. Back-to-back with backpressure:
   - Stream 6 operations; hold out_ready=0 for 3 cycles once out_valid rises.
   - in_ready=0 during the stall, result held stable.
   - All 6 results emerge in order with no gaps once out_ready=1.
5. Reset mid-operation:
   - Accept 2 operations; pulse rst_n low asynchronously between clock edges.
   - out_valid=0 and sum=0 immediately.
   - Neither result ever appears; a new operation issued after release has 4-cycle latency.
6. STAGES=1 instance (WIDTH=8, SEG=8): a=0x80, b=0x80 → 1 cycle later sum=0x00, sal_acarreo=1, overflow=1.
